// File: rtl/can_frame_receiver_if.sv
// can_frame_receiver_if: bus bundle between a CAN-style frame receiver and its
// environment.
// Handshake: valid is a one-cycle strobe with no back-pressure (there is no
// ready). id_out/data_out change only in the cycle valid is high and hold
// otherwise. frame_err is an exclusive one-cycle strobe.
// state_dbg mirrors the receiver FSM state for observation only.
`timescale 1ns/1ps
interface can_frame_receiver_if;
    logic        rx;
    logic [10:0] id_out;
    logic [7:0]  data_out;
    logic        valid;
    logic        busy;
    logic        frame_err;
    logic [2:0]  state_dbg;

    // Environment / bus side: drives the line and observes the results
    modport master (
        output rx,
        input  id_out, data_out, valid, busy, frame_err, state_dbg
    );

    // Receiver side
    modport slave (
        input  rx,
        output id_out, data_out, valid, busy, frame_err, state_dbg
    );
endinterface

// File: rtl/can_frame_receiver.sv
// can_frame_receiver: deserialises START, ID[0..10], GAP1, DATA[0..7], GAP2,
// STOP (23 bit times) from a single-wire line that idles high. Each bit is
// sampled at mid-bit using a clock divider restarted at start-bit detection.
// Optional build macro STOP_CHECK_EN: a low stop sample raises frame_err
// instead of valid. Without it the stop sample is ignored and frame_err is 0.
`timescale 1ns/1ps
module can_frame_receiver #(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    can_frame_receiver_if.slave bus
);
    localparam int DIV_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HALF_LAST_I = (CLKS_PER_BIT > 1) ? (CLKS_PER_BIT / 2) - 1 : 0;
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(HALF_LAST_I);
    localparam logic [DIV_W-1:0] FULL_LAST = DIV_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ID    = 3'd2,
        GAP1  = 3'd3,
        DATA  = 3'd4,
        GAP2  = 3'd5,
        STOP  = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [DIV_W-1:0]       div_q;
    logic [3:0]             bit_q;
    logic [10:0]            id_sr;
    logic [7:0]             data_sr;
    logic                   tick;
    logic                   shift_id;
    logic                   shift_data;
    logic                   accept;
    logic                   valid_q;
    logic [10:0]            id_q;
    logic [7:0]             data_q;
`ifdef STOP_CHECK_EN
    logic                   reject;
    logic                   err_q;
`endif

    assign rxs = sync_q[SYNC_STAGES-1];

    // Input synchroniser; resets to the idle (high) line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= bus.rx;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Sample-point strobe: every clock at one clock per bit, otherwise half a
    // bit into START and a full bit after each earlier sample
    always_comb begin
        tick = 1'b1;
        if (CLKS_PER_BIT > 1) begin
            if (state_q == START) tick = (div_q == HALF_LAST);
            else                  tick = (div_q == FULL_LAST);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state and per-sample actions
    always_comb begin
        state_d    = state_q;
        shift_id   = 1'b0;
        shift_data = 1'b0;
        accept     = 1'b0;
`ifdef STOP_CHECK_EN
        reject     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // With one clock per bit the detecting sample is also the start sample
                if (!rxs) state_d = (CLKS_PER_BIT == 1) ? ID : START;
            end
            START: begin
                if (tick) state_d = rxs ? IDLE : ID;
            end
            ID: begin
                if (tick) begin
                    shift_id = 1'b1;
                    if (bit_q == 4'd10) state_d = GAP1;
                end
            end
            GAP1: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_data = 1'b1;
                    if (bit_q == 4'd7) state_d = GAP2;
                end
            end
            GAP2: begin
                if (tick) state_d = STOP;
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
`ifdef STOP_CHECK_EN
                    if (rxs) accept = 1'b1;
                    else     reject = 1'b1;
`else
                    accept = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bit and divider counters; both restart on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            bit_q <= '0;
        end else if (state_d != state_q) begin
            div_q <= '0;
            bit_q <= '0;
        end else if (state_q != IDLE) begin
            if (tick) begin
                div_q <= '0;
                bit_q <= bit_q + 4'd1;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    // Shift registers, written LSB first at the bit counter index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_sr   <= '0;
            data_sr <= '0;
        end else begin
            if (shift_id)   id_sr[bit_q]        <= rxs;
            if (shift_data) data_sr[bit_q[2:0]] <= rxs;
        end
    end

    // Output registers: results load only with the valid strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            id_q    <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                id_q   <= id_sr;
                data_q <= data_sr;
            end
        end
    end

`ifdef STOP_CHECK_EN
    // Frame error strobe for a low stop sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= reject;
    end
    assign bus.frame_err = err_q;
`else
    assign bus.frame_err = 1'b0;
`endif

    assign bus.valid     = valid_q;
    assign bus.id_out    = id_q;
    assign bus.data_out  = data_q;
    assign bus.busy      = (state_q != IDLE) || !rxs;
    assign bus.state_dbg = state_q;
endmodule
